// File: rtl/ball_pkg.sv
// Shared types and playfield geometry for the ball motion engine.
// States, coordinate widths and sprite constants used by ball_motion_ctrl.
package ball_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_AIR  = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam int PLAY_W    = 400;
  localparam int SPRITE_W  = 72;
  localparam int SPRITE_CX = 36;

  localparam int X_W      = 10;
  localparam int Y_W      = 16;
  localparam int OFS_W    = 9;
  localparam int VEL_W    = 6;
  localparam int OFS_C_W  = 10;  // signed working width for height arithmetic
  localparam int SPD_W    = 4;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: one-cycle pulse every TICK_DIV clocks.
// Counter runs 0..TICK_DIV-1 and tick is high while it sits at TICK_DIV-1.
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic clrn,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clrn)             cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball game-state and physics engine: lateral move, forward scroll, jump arc, ground check.
// Optional build macro SPEEDUP_EN: forward speed grows by one every 1024 map units up to SPEED_MAX.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int TICK_DIV  = 833333,
  parameter int X_INIT    = (PLAY_W - SPRITE_W) / 2,
  parameter int X_MAX     = PLAY_W - SPRITE_W,
  parameter int X_STEP    = 4,
  parameter int SPEED     = 2,
  parameter int SPEED_MAX = 8,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1,
  parameter int OFS_MAX   = 300
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  input  logic             tile_solid,
  output logic [X_W-1:0]   query_x,
  output logic [Y_W-1:0]   query_y,
  output logic [X_W-1:0]   x_ball,
  output logic [Y_W-1:0]   y_ball,
  output logic [OFS_W-1:0] y_pixel_offset,
  output logic             fail
);

  // Base speed never exceeds the ceiling.
  localparam int SPEED_BASE = (SPEED < SPEED_MAX) ? SPEED : SPEED_MAX;

  localparam logic [X_W-1:0]            X_RST    = X_W'(X_INIT);
  localparam logic [X_W-1:0]            X_STEP_V = X_W'(X_STEP);
  localparam logic [X_W:0]              X_STEP_W = (X_W+1)'(X_STEP);
  localparam logic [X_W:0]              X_MAX_W  = (X_W+1)'(X_MAX);
  localparam logic signed [VEL_W-1:0]   JUMP_VEL = VEL_W'(JUMP_V);
  localparam logic signed [VEL_W-1:0]   GRAV_VEL = VEL_W'(GRAVITY);
  localparam logic signed [OFS_C_W-1:0] OFS_CAP  = OFS_C_W'(OFS_MAX);
  localparam logic [SPD_W-1:0]          SPD_BASE = SPD_W'(SPEED_BASE);

  state_t                    state_q, state_d;
  logic [X_W-1:0]            x_q, x_d, x_upd;
  logic [Y_W-1:0]            y_q, y_d, y_adv;
  logic [OFS_W-1:0]          ofs_q, ofs_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic signed [OFS_C_W-1:0] ofs_ext, vel_ext, ofs_sum;
  logic                      jump_q, jump_latch_q, jump_latch_d, jump_rise;
  logic                      start_q;
  logic [SPD_W-1:0]          speed;
  logic                      tick;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .clrn (clrn),
    .tick (tick)
  );

  function automatic logic [X_W-1:0] x_next(input logic [X_W-1:0] x,
                                            input logic left, input logic right);
    logic [X_W:0] sum;
    sum    = {1'b0, x} + X_STEP_W;
    x_next = x;
    if (left && !right)      x_next = (x >= X_STEP_V) ? x - X_STEP_V : '0;
    else if (right && !left) x_next = (sum > X_MAX_W) ? X_MAX_W[X_W-1:0] : sum[X_W-1:0];
  endfunction

  assign x_upd     = x_next(x_q, btn_left, btn_right);
  assign y_adv     = y_q + Y_W'(speed);
  assign jump_rise = btn_jump && !jump_q;
  assign ofs_ext   = {1'b0, ofs_q};
  assign vel_ext   = vel_q;
  assign ofs_sum   = ofs_ext + vel_ext;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    ofs_d        = ofs_q;
    vel_d        = vel_q;
    jump_latch_d = jump_latch_q;
    if (state_q == S_RUN && jump_rise) jump_latch_d = 1'b1;
    unique case (state_q)
      S_IDLE: if (start && !start_q) state_d = S_RUN;
      S_RUN: if (tick) begin
        jump_latch_d = 1'b0;
        if (!tile_solid) state_d = S_FAIL;
        else begin
          y_d = y_adv;
          x_d = x_upd;
          if (jump_latch_q || jump_rise) begin
            state_d = S_AIR;
            vel_d   = JUMP_VEL;
          end
        end
      end
      S_AIR: if (tick) begin
        jump_latch_d = 1'b0;
        y_d          = y_adv;
        x_d          = x_upd;
        vel_d        = vel_q - GRAV_VEL;
        if (ofs_sum <= 0) begin
          ofs_d   = '0;
          vel_d   = '0;
          state_d = S_RUN;
        end else if (ofs_sum > OFS_CAP) begin
          ofs_d = OFS_CAP[OFS_W-1:0];
        end else begin
          ofs_d = ofs_sum[OFS_W-1:0];
        end
      end
      S_FAIL: if (start) begin
        state_d = S_IDLE;
        x_d     = X_RST;
        y_d     = '0;
        ofs_d   = '0;
        vel_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q      <= S_IDLE;
      x_q          <= X_RST;
      y_q          <= '0;
      ofs_q        <= '0;
      vel_q        <= '0;
      jump_q       <= 1'b0;
      jump_latch_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ofs_q        <= ofs_d;
      vel_q        <= vel_d;
      jump_q       <= btn_jump;
      jump_latch_q <= jump_latch_d;
      start_q      <= start;
    end
  end

`ifdef SPEEDUP_EN
  logic [SPD_W-1:0] speed_d;
  logic [10:0]      y_lo_sum;
  logic             moved, restart;

  // Carry out of y[9:0] marks another 1024 units travelled.
  assign y_lo_sum = {1'b0, y_q[9:0]} + 11'(speed);
  assign moved    = tick && ((state_q == S_RUN && tile_solid) || state_q == S_AIR);
  assign restart  = (state_q == S_FAIL) && start;

  always_comb begin
    speed_d = speed;
    if (restart) speed_d = SPD_BASE;
    else if (moved && y_lo_sum[10] && speed < SPD_W'(SPEED_MAX)) speed_d = speed + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) speed <= SPD_BASE;
    else       speed <= speed_d;
  end
`else
  assign speed = SPD_BASE;
`endif

  assign x_ball         = x_q;
  assign y_ball         = y_q;
  assign y_pixel_offset = ofs_q;
  assign query_x        = x_q + X_W'(SPRITE_CX);
  assign query_y        = y_q;
  assign fail           = (state_q == S_FAIL);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: scoreboard of expected outputs per physics tick.
// Main instance uses TICK_DIV=4; a second TICK_DIV=1 instance covers the 16-bit y wrap.
module tb_ball_motion_ctrl;
  import ball_pkg::*;

  localparam int TDIV = 4;

  typedef struct packed {
    logic [9:0]  x;
    logic [15:0] y;
    logic [8:0]  ofs;
    logic        fail;
  } obs_t;

  logic clk = 1'b0;
  logic clrn, start, btn_left, btn_right, btn_jump, tile_solid;
  logic [9:0]  query_x, x_ball;
  logic [15:0] query_y, y_ball;
  logic [8:0]  y_pixel_offset;
  logic        fail;

  logic clrn_f, start_f;
  logic [9:0]  query_x_f, x_ball_f;
  logic [15:0] query_y_f, y_ball_f;
  logic [8:0]  ofs_f;
  logic        fail_f;

  obs_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [9:0]  ex;
  logic [15:0] ey;
  logic [8:0]  eofs;

  always #5 clk = ~clk;

  ball_motion_ctrl #(.TICK_DIV(TDIV)) u_dut (
    .clk(clk), .clrn(clrn), .start(start), .btn_left(btn_left), .btn_right(btn_right),
    .btn_jump(btn_jump), .tile_solid(tile_solid), .query_x(query_x), .query_y(query_y),
    .x_ball(x_ball), .y_ball(y_ball), .y_pixel_offset(y_pixel_offset), .fail(fail)
  );

  ball_motion_ctrl #(.TICK_DIV(1)) u_fast (
    .clk(clk), .clrn(clrn_f), .start(start_f), .btn_left(1'b0), .btn_right(1'b0),
    .btn_jump(1'b0), .tile_solid(1'b1), .query_x(query_x_f), .query_y(query_y_f),
    .x_ball(x_ball_f), .y_ball(y_ball_f), .y_pixel_offset(ofs_f), .fail(fail_f)
  );

  // Mirrors the DUT tick phase: a tick update lands on every posedge where cyc becomes a multiple of TDIV.
  always @(posedge clk) begin
    if (!clrn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic obs_t main_obs();
    return obs_t'{x_ball, y_ball, y_pixel_offset, fail};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("x=%0d y=%0d ofs=%0d fail=%0b", o.x, o.y, o.ofs, o.fail);
  endfunction

  task automatic do_tick();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % TDIV != 0);
  endtask

  task automatic pulse_jump();
    btn_jump = 1'b1;
    @(posedge clk);
    #1 btn_jump = 1'b0;
  endtask

  task automatic apply_reset();
    clrn = 1'b0; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    btn_jump = 1'b0; tile_solid = 1'b1;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    ex = 10'd164; ey = '0; eofs = '0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    apply_reset();
    got = main_obs();
    n_checks++;
    if (got !== obs_t'{10'd164, 16'd0, 9'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got %s, want x=164 y=0 ofs=0 fail=0", fmt(got));
    end
    n_checks++;
    if (query_x !== 10'd200 || query_y !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_query: got qx=%0d qy=%0d, want qx=200 qy=0", query_x, query_y);
    end
    // IDLE must ignore buttons and ground.
    btn_right = 1'b1; tile_solid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
      do_tick();
      got = main_obs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL idle_frozen[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
      end
    end
    btn_right = 1'b0; tile_solid = 1'b1;
  endtask

  task automatic test_run_forward();
    obs_t got, exp;
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ey = ey + 16'd2;
      sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
      do_tick();
      got = main_obs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL run_forward[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
      end
    end
    n_checks++;
    if (query_x !== 10'd200 || query_y !== 16'd20) begin
      n_fail++;
      $display("FAIL run_query: got qx=%0d qy=%0d, want qx=200 qy=20", query_x, query_y);
    end
    start = 1'b0;
  endtask

  task automatic test_lateral();
    obs_t got, exp;
    logic [9:0] left_tbl  [5] = '{10'd4, 10'd0, 10'd0, 10'd0, 10'd0};
    logic [9:0] right_tbl [5] = '{10'd328, 10'd328, 10'd328, 10'd328, 10'd328};
    logic [1:0] btn_tbl   [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00};  // {left,right}
    btn_left = 1'b1;
    for (int i = 0; i < 44; i++) begin
      ex = (i < 39) ? ex - 10'd4 : left_tbl[i-39];
      ey = ey + 16'd2;
      sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
      do_tick();
      got = main_obs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL move_left[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
      end
    end
    btn_left = 1'b0; btn_right = 1'b1;
    for (int i = 0; i < 86; i++) begin
      if (i >= 81) {btn_left, btn_right} = btn_tbl[i-81];
      ex = (i < 81) ? ex + 10'd4 : right_tbl[i-81];
      ey = ey + 16'd2;
      sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
      do_tick();
      got = main_obs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL move_right[%0d]: got %s, want %s", i, fmt(got), fmt(exp));
      end
    end
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic test_jump();
    obs_t got, exp;
    int   h;
    pulse_jump();
    for (int k = 0; k <= 27; k++) begin
      if (k == 3)  tile_solid = 1'b0;
      if (k == 5)  pulse_jump();
      if (k == 8)  btn_left = 1'b1;
      if (k == 11) btn_left = 1'b0;
      if (k == 20) tile_solid = 1'b1;
      h = (k >= 1 && k < 25) ? 12 * k - (k * (k - 1)) / 2 : 0;
      eofs = 9'(h);
      if (k >= 8 && k <= 10) ex = ex - 10'd4;
      ey = ey + 16'd2;
      sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
      do_tick();
      got = main_obs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL jump_arc[%0d]: got %s, want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_fail_restart();
    obs_t got, exp;
    tile_solid = 1'b0;
    sb.push_back(obs_t'{ex, ey, eofs, 1'b1});
    do_tick();
    got = main_obs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL fall_off: got %s, want %s", fmt(got), fmt(exp));
    end
    tile_solid = 1'b1; btn_right = 1'b1;
    sb.push_back(obs_t'{ex, ey, eofs, 1'b1});
    do_tick();
    got = main_obs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL fail_frozen: got %s, want %s", fmt(got), fmt(exp));
    end
    btn_right = 1'b0;
    start = 1'b1;
    ex = 10'd164; ey = '0; eofs = '0;
    sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
    @(posedge clk); #1;
    got = main_obs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL restart_values: got %s, want %s", fmt(got), fmt(exp));
    end
    // Held start must not launch a new run.
    sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
    do_tick();
    got = main_obs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL restart_needs_edge: got %s, want %s", fmt(got), fmt(exp));
    end
    start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    ey = 16'd2;
    sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
    do_tick();
    got = main_obs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL rerun: got %s, want %s", fmt(got), fmt(exp));
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_air();
    obs_t got, exp;
    int   seq [5] = '{0, 12, 23, 33, 42};
    pulse_jump();
    for (int k = 0; k < 5; k++) begin
      eofs = 9'(seq[k]);
      ey = ey + 16'd2;
      sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
      do_tick();
      got = main_obs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL air_before_reset[%0d]: got %s, want %s", k, fmt(got), fmt(exp));
      end
    end
    clrn = 1'b0;
    ex = 10'd164; ey = '0; eofs = '0;
    sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
    @(posedge clk); #1 clrn = 1'b1;
    got = main_obs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_air: got %s, want %s", fmt(got), fmt(exp));
    end
    sb.push_back(obs_t'{ex, ey, eofs, 1'b0});
    do_tick();
    got = main_obs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %s, want %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_y_wrap();
    obs_t        got, exp;
    logic [15:0] ey_f = '0;
    int          spd = 2;
    int          lo;
    @(posedge clk); #1 clrn_f = 1'b1; start_f = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 32768; n++) begin
      lo   = int'(ey_f[9:0]) + spd;
      ey_f = ey_f + 16'(spd);
`ifdef SPEEDUP_EN
      if (lo >= 1024 && spd < 8) spd++;
`else
      if (lo < 0) spd = 0;
`endif
      if (n % 1024 == 0 || n >= 32766) sb.push_back(obs_t'{10'd164, ey_f, 9'd0, 1'b0});
      @(posedge clk); #1;
      if (n % 1024 == 0 || n >= 32766) begin
        got = obs_t'{x_ball_f, y_ball_f, ofs_f, fail_f}; exp = sb.pop_front(); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL fast_run[%0d]: got %s, want %s", n, fmt(got), fmt(exp));
        end
`ifndef SPEEDUP_EN
        if (n == 32767) begin
          n_checks++;
          if (y_ball_f !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL y_before_wrap: got %h, want fffe", y_ball_f);
          end
        end
        if (n == 32768) begin
          n_checks++;
          if (y_ball_f !== 16'h0000) begin
            n_fail++;
            $display("FAIL y_wrap: got %h, want 0000", y_ball_f);
          end
        end
`endif
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clrn_f = 1'b0; start_f = 1'b0;
    test_reset();
    test_run_forward();
    test_lateral();
    test_jump();
    test_fail_restart();
    test_reset_mid_air();
    test_y_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
